// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and endian-aware lane helpers for mem_subword_unit.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WB} state_t;

    // Bit position of the addressed lane's LSB inside the 32-bit word.
    function automatic logic [4:0] lane_shift(input logic be, input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_H)
            return be ? {~off[1], 4'b0} : {off[1], 4'b0};
        return be ? {~off, 3'b0} : {off, 3'b0};
    endfunction

    function automatic logic [31:0] lane_extract(input logic be, input logic [31:0] word,
                                                 input logic [1:0] size, input logic [1:0] off,
                                                 input logic uns);
        logic [31:0] s;
        s = word >> lane_shift(be, size, off);
        if (size == SZ_B)
            return {{24{s[7] & ~uns}}, s[7:0]};
        if (size == SZ_H)
            return {{16{s[15] & ~uns}}, s[15:0]};
        return word;
    endfunction

    function automatic logic [31:0] lane_merge(input logic be, input logic [31:0] word,
                                               input logic [31:0] wdata, input logic [1:0] size,
                                               input logic [1:0] off);
        logic [31:0] m;
        logic [4:0]  sh;
        if (size == SZ_W)
            return wdata;
        m  = (size == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh = lane_shift(be, size, off);
        return (word & ~(m << sh)) | ((wdata & m) << sh);
    endfunction

endpackage

// File: rtl/word_ram.sv
// word_ram: single-port 32-bit synchronous RAM, registered read, no byte enables.
module word_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i)
            mem[addr_i] <= wdata_i;
        if (re_i)
            rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_subword_unit.sv
// mem_subword_unit: byte/half/word loads and stores over a word RAM,
// sub-word stores done as read-modify-write.
module mem_subword_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata
);

    state_t            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              acc, req_err, ram_we;
    logic [31:0]       ram_rdata, ram_wdata;

    assign req_ready = (state_q == IDLE) && reset;
    assign acc       = req_valid && req_ready;
    assign req_err   = (req_size == 2'b11) || (req_size == SZ_H && req_addr[0]) ||
                       (req_size == SZ_W && req_addr[1:0] != 2'b00);

    // Errors and word stores need no read, so they go straight to WB.
    always_comb begin
        state_d     = (state_q == RD) ? WB :
                      (state_q == WB) ? IDLE :
                      acc ? ((req_err || (req_we && req_size == SZ_W)) ? WB : RD) : IDLE;
        we_d        = acc ? req_we       : we_q;
        size_d      = acc ? req_size     : size_q;
        uns_d       = acc ? req_unsigned : uns_q;
        addr_d      = acc ? req_addr     : addr_q;
        wdata_d     = acc ? req_wdata    : wdata_q;
        err_d       = acc ? req_err      : err_q;
        ram_we      = (state_q == WB) && we_q && !err_q;
        ram_wdata   = lane_merge(BIG_ENDIAN, ram_rdata, wdata_q, size_q, addr_q[1:0]);
        rsp_valid_d = (state_q == WB);
        rsp_err_d   = (state_q == WB) && err_q;
        rsp_rdata_d = ((state_q == WB) && !err_q && !we_q) ?
                      lane_extract(BIG_ENDIAN, ram_rdata, size_q, addr_q[1:0], uns_q) : 32'h0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk_i   (CLK),
        .re_i    (state_q == RD),
        .we_i    (ram_we),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
